// File: rtl/serial_add_seq_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM state encoding
// and the default operand width.
package serial_add_seq_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_fa_bit.sv
// One-bit full adder with its carry flop; the carry is preloaded at operation
// start and advanced once per serial step.
module serial_fa_bit (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_load_val,
  input  logic i_en,
  input  logic i_a,
  input  logic i_b,
  output logic o_s_c,
  output logic o_cnext_c,
  output logic o_c
);

  logic r_c;

  assign o_s_c     = i_a ^ i_b ^ r_c;
  assign o_cnext_c = (i_a & i_b) | (i_a & r_c) | (i_b & r_c);
  assign o_c       = r_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_c <= 1'b0;
    end else if (i_load) begin
      r_c <= i_load_val;
    end else if (i_en) begin
      r_c <= o_cnext_c;
    end
  end

endmodule

// File: rtl/serial_add_seq.sv
// Bit-serial add/subtract: one result bit per cycle, LSB first, with a
// valid/ready handshake on both sides and no overlap between operations.
module serial_add_seq
  import serial_add_seq_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int unsigned CW = $clog2(WIDTH);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_accept;
  logic             w_shift;
  logic             w_last;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_ra;
  logic [WIDTH-1:0] r_rb;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_busy;
  logic             w_s;
  logic             w_cnext;
  logic             w_c;

  // Next-state and step strobes
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_shift     = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        w_shift = 1'b1;
        if (r_cnt == CW'(WIDTH - 1)) begin
          w_last      = 1'b1;
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register; status outputs are registered from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt == ST_IDLE);
      r_out_valid <= (w_state_nxt == ST_DONE);
      r_busy      <= (w_state_nxt == ST_SHIFT);
    end
  end

  serial_fa_bit u_fa (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_accept),
    .i_load_val (sub),
    .i_en       (w_shift),
    .i_a        (r_ra[0]),
    .i_b        (r_rb[0]),
    .o_s_c      (w_s),
    .o_cnext_c  (w_cnext),
    .o_c        (w_c)
  );

  // Operand/result shift registers and bit counter; counter holds on the last step
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ra   <= '0;
      r_rb   <= '0;
      r_sum  <= '0;
      r_cnt  <= '0;
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (w_accept) begin
      r_ra  <= a;
      r_rb  <= sub ? ~b : b;
      r_cnt <= '0;
    end else if (w_shift) begin
      r_ra  <= r_ra >> 1;
      r_rb  <= r_rb >> 1;
      r_sum <= {w_s, r_sum[WIDTH-1:1]};
      if (w_last) begin
        r_cout <= w_cnext;
        r_ovf  <= w_c ^ w_cnext;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_serial_add_seq.sv
// Scoreboard bench for serial_add_seq: the driver queues hand-computed results,
// a negedge monitor checks each new result as out_valid rises.
module tb_serial_add_seq;

  localparam int unsigned W = 8;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int           stall;
    bit           noise;
  } vec_t;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         busy;

  int   n_assert = 0;
  int   n_fail   = 0;
  exp_t q[$];
  logic prev_ov  = 1'b0;
  vec_t vecs[8];

  serial_add_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: one scoreboard pop per rising out_valid
  always @(negedge clk) begin
    if (out_valid === 1'b1 && prev_ov === 1'b0) begin
      if (q.size() == 0) begin
        check("unexpected_result", 32'(out_valid), 32'(0));
      end else begin
        exp_t e;
        e = q.pop_front();
        check("sum", 32'(sum), 32'(e.sum));
        check("cout", 32'(cout), 32'(e.cout));
        check("ovf", 32'(ovf), 32'(e.ovf));
      end
    end
    prev_ov <= out_valid;
  end

  task automatic wait_idle();
    int w = 0;
    while (in_ready !== 1'b1 && w < 40) begin
      @(negedge clk);
      w++;
    end
    if (w >= 40) check("idle_timeout", 32'(0), 32'(1));
  endtask

  // Issue one operation starting from a negedge; returns at a negedge in IDLE
  task automatic do_op(input vec_t v);
    int   n;
    exp_t e;
    wait_idle();
    in_valid  = 1'b1;
    a         = v.a;
    b         = v.b;
    sub       = v.s;
    out_ready = (v.stall == 0);
    e.sum = v.sum; e.cout = v.cout; e.ovf = v.ovf;
    q.push_back(e);
    @(posedge clk);
    #1;
    if (v.noise) begin
      a   = W'($urandom);
      b   = W'($urandom);
      sub = ~v.s;
    end else begin
      in_valid = 1'b0;
    end
    n = 1;
    forever begin
      @(negedge clk);
      if (n == 1) begin
        check("busy_in_shift", 32'(busy), 32'(1));
        check("in_ready_in_shift", 32'(in_ready), 32'(0));
      end
      if (out_valid === 1'b1) break;
      if (n > 3 * W) begin
        check("out_valid_timeout", 32'(0), 32'(1));
        break;
      end
      @(posedge clk);
      n++;
    end
    check("latency", 32'(n), 32'(W + 1));
    in_valid = 1'b0;
    for (int i = 0; i < v.stall; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("stall_out_valid", 32'(out_valid), 32'(1));
      check("stall_in_ready", 32'(in_ready), 32'(0));
      check("stall_sum", 32'(sum), 32'(v.sum));
      check("stall_cout", 32'(cout), 32'(v.cout));
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("released_out_valid", 32'(out_valid), 32'(0));
    check("released_in_ready", 32'(in_ready), 32'(1));
  endtask

  initial begin
    vec_t v;
    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    sub       = 1'b0;
    out_ready = 1'b0;

    vecs[0] = '{8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, 1'b0, 0, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0};
    vecs[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 0, 1'b0};
    vecs[3] = '{8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0, 5, 1'b0};
    vecs[4] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 0, 1'b1};
    vecs[5] = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 2, 1'b1};
    vecs[6] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 0, 1'b0};
    vecs[7] = '{8'h7F, 8'h80, 1'b1, 8'hFF, 1'b0, 1'b1, 1, 1'b0};

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'(1));
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_sum", 32'(sum), 32'(0));
    check("rst_cout", 32'(cout), 32'(0));
    check("rst_ovf", 32'(ovf), 32'(0));

    foreach (vecs[i]) do_op(vecs[i]);

    // Reset on the 4th shift edge discards the in-flight operation
    wait_idle();
    in_valid  = 1'b1;
    a         = 8'hAA;
    b         = 8'h55;
    sub       = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_in_ready", 32'(in_ready), 32'(1));
    check("midrst_out_valid", 32'(out_valid), 32'(0));
    check("midrst_busy", 32'(busy), 32'(0));
    check("midrst_sum", 32'(sum), 32'(0));
    check("midrst_cout", 32'(cout), 32'(0));
    check("midrst_ovf", 32'(ovf), 32'(0));

    v = '{8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0, 0, 1'b0};
    do_op(v);

    repeat (2) @(negedge clk);
    check("scoreboard_empty", 32'(q.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_add_seq.md
SERIAL_ADD_SEQ -- requirements
Module: serial_add_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, the operand and result width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port in_valid  input  1  an operand pair and mode are presented.
REQ-005 SHALL have port in_ready  output  1  the block can accept an operand pair.
REQ-006 SHALL have port a  input  WIDTH  first operand, unsigned or two's complement.
REQ-007 SHALL have port b  input  WIDTH  second operand.
REQ-008 SHALL have port sub  input  1  0 = a+b, 1 = a-b.
REQ-009 SHALL have port out_valid  output  1  result fields are valid.
REQ-010 SHALL have port out_ready  input  1  the consumer takes the result.
REQ-011 SHALL have port sum  output  WIDTH  result, LSB first computed.
REQ-012 SHALL have port cout  output  1  final carry (add) or not-borrow (sub).
REQ-013 SHALL have port ovf  output  1  signed overflow of the operation.
REQ-014 SHALL have port busy  output  1  a serial operation is in progress (state SHIFT).

Function
REQ-015 SHALL implement a state machine with states IDLE, SHIFT and DONE.
REQ-016 In IDLE, in_ready SHALL be 1; in SHIFT and DONE, in_ready SHALL be 0.
REQ-017 Acceptance SHALL occur on an edge where state=IDLE and in_valid=1: capture a into register ra, capture (sub ? ~b : b) into rb, set the carry flop to sub, clear the bit counter, and go to SHIFT.
REQ-018 Each SHIFT edge SHALL compute s = ra[0]^rb[0]^c and cnext = majority(ra[0],rb[0],c).
- On the same edge it SHALL shift ra and rb right by one and shift s into the MSB of the sum register.
- It SHALL update c to cnext and increment the counter.
REQ-019 On the SHIFT edge with counter = WIDTH-1, the block SHALL latch ovf = c ^ cnext (carry into MSB xor carry out) and cout = cnext, and go to DONE.
REQ-020 out_valid SHALL be 1 exactly in DONE.
- It first rises after the WIDTH-th edge following the acceptance edge, giving a latency of WIDTH+1 edges from acceptance to the first out_valid cycle.
REQ-021 In DONE, sum, cout and ovf SHALL stay stable until the edge where out_ready=1; that edge SHALL return the state to IDLE.
REQ-022 out_ready SHALL be ignored outside DONE; in_valid, a, b and sub SHALL be ignored outside IDLE.
REQ-023 Throughput SHALL be one operation per WIDTH+2 cycles when out_ready is held at 1; no overlap of consecutive operations.
REQ-024 Arithmetic SHALL be modulo 2^WIDTH, so subtraction a-b equals a + ~b + 1.
REQ-025 The counter SHALL be $clog2(WIDTH) bits wide and SHALL NOT wrap while in SHIFT.
REQ-026 The sum register SHALL hold its last value in IDLE; it is meaningful only while out_valid=1.

Reset
REQ-027 When rst=1 at an edge, the block SHALL enter IDLE regardless of state, including mid-SHIFT and in DONE with the result not yet taken; the in-flight operation SHALL be discarded.
REQ-028 Reset values SHALL be: in_ready=1, out_valid=0, busy=0, sum=0, cout=0, ovf=0, carry flop=0, counter=0, ra=0, rb=0.
REQ-029 rst SHALL take priority over in_valid and out_ready on the same edge.

Structure
REQ-030 A shared package SHALL hold the state encoding (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) and the default WIDTH constant.
REQ-031 One sub-module, serial_fa_bit, SHALL provide the one-bit full adder with its carry flop, with load and enable controls.
REQ-032 The top level SHALL hold the FSM, the counter, and the ra, rb and sum shift registers.

Verification
REQ-033 Reset, then a=8'h3C, b=8'h0F, sub=0 accepted -> out_valid after 9 edges, with sum=8'h4B, cout=0, ovf=0.
REQ-034 a=8'hFF, b=8'h01, sub=0 -> sum=8'h00, cout=1, ovf=0; a=8'h7F, b=8'h01 -> sum=8'h80, cout=0, ovf=1.
REQ-035 a=8'h05, b=8'h07, sub=1 -> sum=8'hFE, cout=0, ovf=0; a=8'h80, b=8'h01, sub=1 -> sum=8'h7F, cout=1, ovf=1.
REQ-036 Hold out_ready=0 for 5 cycles in DONE -> out_valid, sum and cout stay stable and in_ready stays 0; out_ready=1 -> IDLE on the next edge.
REQ-037 Assert rst on the 4th SHIFT edge -> IDLE and reset values on the next cycle; a new pair a=8'h01, b=8'h02 then yields sum=8'h03.
